// File: rtl/vga_rx.sv
// vga_rx - receive-side VGA timing decoder.
//
// Samples hsync/vsync/rgb30 on the pixel clock, recovers the line/frame
// position, checks the stream against the configured mode and, once
// LOCK_FRAMES consecutive conforming frames have been seen, emits
// per-pixel active-region coordinates with a valid strobe.
//
// Ports:
//   clk          pixel clock, all logic on the rising edge
//   rst_n        asynchronous active-low reset
//   hsync/vsync  active-low syncs
//   rgb30        pixel data {R[9:0],G[9:0],B[9:0]}
//   pix_x/pix_y  active column/row (updated every cycle)
//   pix_rgb      pixel data aligned with pix_x/pix_y
//   pix_valid    active-region pixel while locked
//   frame_start  one-cycle pulse at each detected frame start
//   locked       timing matches the configured mode
//   err          one-cycle pulse on any timing violation
//   h_total      last measured line period, clocks
//   v_total      last measured frame period, lines
//   err_cnt      saturating violation count
//
// Optional feature: define VGA_RX_STATS_EN to build the err_cnt counter;
// without it err_cnt is tied to 0.
module vga_rx #(
    parameter int HA          = 128,
    parameter int HB          = 88,
    parameter int HC          = 800,
    parameter int HE          = 1056,
    parameter int VA          = 4,
    parameter int VB          = 23,
    parameter int VC          = 600,
    parameter int VE          = 628,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [29:0] rgb30,
    output logic [10:0] pix_x,
    output logic [9:0]  pix_y,
    output logic [29:0] pix_rgb,
    output logic        pix_valid,
    output logic        frame_start,
    output logic        locked,
    output logic        err,
    output logic [11:0] h_total,
    output logic [10:0] v_total,
    output logic [15:0] err_cnt
);

    typedef enum logic [1:0] {SEARCH = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_t;

    localparam logic [11:0] H_LEN  = 12'(HE);
    localparam logic [11:0] HS_LEN = 12'(HA);
    localparam logic [11:0] H_ACT0 = 12'(HA + HB);
    localparam logic [11:0] H_ACT1 = 12'(HA + HB + HC);
    localparam logic [10:0] V_LEN  = 11'(VE);
    localparam logic [10:0] VS_LEN = 11'(VA);
    localparam logic [10:0] V_ACT0 = 11'(VA + VB);
    localparam logic [10:0] V_ACT1 = 11'(VA + VB + VC);
    localparam logic [7:0]  GOOD_N = 8'(LOCK_FRAMES);

    function automatic logic [11:0] sat_inc12(input logic [11:0] a);
        return (a == 12'hFFF) ? a : a + 12'd1;
    endfunction

    function automatic logic [10:0] sat_inc11(input logic [10:0] a);
        return (a == 11'h7FF) ? a : a + 11'd1;
    endfunction

    // Stage p0: input register plus the previous registered copy for edge detection.
    // Edge history resets low so a sync already low at reset release is not
    // mistaken for a falling edge.
    logic        hs_p0, vs_p0, hs_prev_p0, vs_prev_p0;
    logic [29:0] rgb_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_p0      <= 1'b0;
            vs_p0      <= 1'b0;
            hs_prev_p0 <= 1'b0;
            vs_prev_p0 <= 1'b0;
        end else begin
            hs_p0      <= hsync;
            vs_p0      <= vsync;
            hs_prev_p0 <= hs_p0;
            vs_prev_p0 <= vs_p0;
        end
    end

    always_ff @(posedge clk) begin
        rgb_p0 <= rgb30;
    end

    // Position tracking state: values belong to the previous sample.
    logic [11:0] h_p1;
    logic [10:0] v_p1;
    logic [10:0] vsl_p1;     // line starts seen while vsync low
    logic        pend_p1;    // vsync fell, waiting for the next line start
    logic [7:0]  good_p1;
    state_t      state, state_nxt;
    logic [7:0]  good_nxt;

    logic        line_start, hs_rise, vs_fall, vs_rise, fs_evt, viol, active;
    logic [11:0] h_inc, h_pos, h_off;
    logic [10:0] v_inc, v_pos, v_off, vsl_base, vsl_nxt;
    logic        pend_nxt;

    always_comb begin
        line_start = ~hs_p0 & hs_prev_p0;
        hs_rise    = hs_p0 & ~hs_prev_p0;
        vs_fall    = ~vs_p0 & vs_prev_p0;
        vs_rise    = vs_p0 & ~vs_prev_p0;
        // A vsync fall coincident with a line start is a frame start on that sample.
        fs_evt     = line_start & (pend_p1 | vs_fall);

        h_inc = sat_inc12(h_p1);
        v_inc = sat_inc11(v_p1);
        h_pos = line_start ? 12'd0 : h_inc;
        if (fs_evt)          v_pos = 11'd0;
        else if (line_start) v_pos = v_inc;
        else                 v_pos = v_p1;

        pend_nxt = fs_evt ? 1'b0 : (vs_fall ? 1'b1 : pend_p1);

        vsl_base = vs_fall ? 11'd0 : vsl_p1;
        vsl_nxt  = (line_start & ~vs_p0) ? sat_inc11(vsl_base) : vsl_base;

        viol = (state != SEARCH) &&
               ((line_start && (h_inc  != H_LEN))  ||
                (hs_rise    && (h_pos  != HS_LEN)) ||
                (vs_rise    && (vsl_p1 != VS_LEN)) ||
                (fs_evt     && (v_inc  != V_LEN)));

        active = (h_pos >= H_ACT0) && (h_pos < H_ACT1) &&
                 (v_pos >= V_ACT0) && (v_pos < V_ACT1);
        h_off  = h_pos - H_ACT0;
        v_off  = v_pos - V_ACT0;
    end

    // Lock FSM: any violation wins over a coincident frame start.
    always_comb begin
        state_nxt = state;
        good_nxt  = good_p1;
        if (viol) begin
            state_nxt = SEARCH;
        end else if (fs_evt) begin
            case (state)
                SEARCH: begin
                    state_nxt = CHECK;
                    good_nxt  = 8'd0;
                end
                CHECK: begin
                    good_nxt = good_p1 + 8'd1;
                    if (good_nxt == GOOD_N) state_nxt = LOCKED;
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_p1    <= '0;
            v_p1    <= '0;
            vsl_p1  <= '0;
            pend_p1 <= 1'b0;
            good_p1 <= '0;
            state   <= SEARCH;
        end else begin
            h_p1    <= h_pos;
            v_p1    <= v_pos;
            vsl_p1  <= vsl_nxt;
            pend_p1 <= pend_nxt;
            good_p1 <= good_nxt;
            state   <= state_nxt;
        end
    end

    assign locked = (state == LOCKED);

    // Stage p1: output register, aligned with the state register so locked
    // rises with the frame_start that completes the lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            err         <= 1'b0;
            h_total     <= '0;
            v_total     <= '0;
        end else begin
            pix_x       <= h_off[10:0];
            pix_y       <= v_off[9:0];
            pix_rgb     <= rgb_p0;
            pix_valid   <= (state_nxt == LOCKED) && active;
            frame_start <= fs_evt;
            err         <= viol;
            if (line_start) h_total <= h_inc;
            if (fs_evt)     v_total <= v_inc;
        end
    end

`ifdef VGA_RX_STATS_EN
    logic [15:0] err_cnt_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_p1 <= '0;
        end else if (viol && (err_cnt_p1 != 16'hFFFF)) begin
            err_cnt_p1 <= err_cnt_p1 + 16'd1;
        end
    end

    assign err_cnt = err_cnt_p1;
`else
    assign err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vga_rx.sv
// Directed bench for vga_rx using a reduced 24x16 mode so whole frames fit
// in a short run: hsync 4, back porch 4, 12 active, 24 total clocks;
// vsync 2, back porch 2, 10 active, 16 total lines.
module tb_vga_rx;

    localparam int HA = 4;
    localparam int HB = 4;
    localparam int HC = 12;
    localparam int HE = 24;
    localparam int VA = 2;
    localparam int VB = 2;
    localparam int VC = 10;
    localparam int VE = 16;

`ifdef VGA_RX_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic [29:0] rgb30 = '0;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic [29:0] pix_rgb;
    logic        pix_valid, frame_start, locked, err;
    logic [11:0] h_total;
    logic [10:0] v_total;
    logic [15:0] err_cnt;

    vga_rx #(
        .HA(HA), .HB(HB), .HC(HC), .HE(HE),
        .VA(VA), .VB(VB), .VC(VC), .VE(VE), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .rgb30(rgb30),
        .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb), .pix_valid(pix_valid),
        .frame_start(frame_start), .locked(locked), .err(err),
        .h_total(h_total), .v_total(v_total), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Event monitor, sampled on the falling edge.
    int          fs_n = 0, err_n = 0, vld_n = 0, lock_rise_fs = -99;
    logic        locked_d = 1'b0, first_pend = 1'b0;
    logic [10:0] first_x = '0, last_x = '0;
    logic [9:0]  first_y = '0, last_y = '0;
    logic [29:0] first_rgb = '0;
    logic [11:0] err_htot = '0;

    always @(negedge clk) begin
        if (frame_start) begin
            fs_n++;
            first_pend = 1'b1;
        end
        if (locked && !locked_d) lock_rise_fs = frame_start ? fs_n : -1;
        locked_d = locked;
        if (err) begin
            err_n++;
            err_htot = h_total;
        end
        if (pix_valid) begin
            vld_n++;
            if (first_pend) begin
                first_x    = pix_x;
                first_y    = pix_y;
                first_rgb  = pix_rgb;
                first_pend = 1'b0;
            end
            last_x = pix_x;
            last_y = pix_y;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " pix_x"}, 32'(pix_x), 32'd0);
        chk({tag, " pix_y"}, 32'(pix_y), 32'd0);
        chk({tag, " pix_rgb"}, 32'(pix_rgb), 32'd0);
        chk({tag, " pix_valid"}, 32'(pix_valid), 32'd0);
        chk({tag, " frame_start"}, 32'(frame_start), 32'd0);
        chk({tag, " locked"}, 32'(locked), 32'd0);
        chk({tag, " err"}, 32'(err), 32'd0);
        chk({tag, " h_total"}, 32'(h_total), 32'd0);
        chk({tag, " v_total"}, 32'(v_total), 32'd0);
        chk({tag, " err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    task automatic px(input logic h, input logic v, input logic [29:0] d);
        @(posedge clk);
        #1;
        hsync = h;
        vsync = v;
        rgb30 = d;
    endtask

    // vsync is low from column vlo_from onward (0 = whole line, >len = never).
    task automatic send_line(input int ln, input int len, input int hlow, input int vlo_from);
        for (int hc = 0; hc < len; hc++)
            px(hc >= hlow, hc < vlo_from, {10'(ln), 10'(hc), 10'h2A5});
    endtask

    task automatic send_frame(input int stretch_ln, input int short_ln);
        for (int ln = 0; ln < VE; ln++)
            send_line(ln, (ln == stretch_ln) ? HE + 1 : HE,
                      (ln == short_ln) ? HA - 1 : HA, (ln < VA) ? 0 : HE + 2);
    endtask

    int fs0, err0, vld0;

    initial begin
        // Reset state
        @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) px(1'b1, 1'b1, 30'd0);

        // Acquisition from reset
        fs0 = fs_n; err0 = err_n; vld0 = vld_n;
        send_frame(-1, -1);
        send_frame(-1, -1);
        chk("no_valid_unlocked", 32'(vld_n - vld0), 32'd0);
        chk("unlocked_after_2", 32'(locked), 32'd0);
        vld0 = vld_n;
        send_frame(-1, -1);
        send_frame(-1, -1);
        chk("fs_count_4", 32'(fs_n - fs0), 32'd4);
        chk("lock_at_fs3", 32'(lock_rise_fs - fs0), 32'd3);
        chk("locked_after_4", 32'(locked), 32'd1);
        chk("no_err_acq", 32'(err_n - err0), 32'd0);
        chk("h_total", 32'(h_total), 32'd24);
        chk("v_total", 32'(v_total), 32'd16);
        chk("valid_frames_3_4", 32'(vld_n - vld0), 32'd240);

        // One locked frame: valid count and first/last pixel
        vld0 = vld_n;
        send_frame(-1, -1);
        chk("valid_per_frame", 32'(vld_n - vld0), 32'd120);
        chk("first_x", 32'(first_x), 32'd0);
        chk("first_y", 32'(first_y), 32'd0);
        chk("first_rgb", 32'(first_rgb), 32'({10'd4, 10'd8, 10'h2A5}));
        chk("last_x", 32'(last_x), 32'd11);
        chk("last_y", 32'(last_y), 32'd9);

        // Stretched line while locked, then relock
        err0 = err_n;
        send_frame(5, -1);
        chk("stretch_err_once", 32'(err_n - err0), 32'd1);
        chk("stretch_h_total", 32'(err_htot), 32'd25);
        chk("stretch_unlocked", 32'(locked), 32'd0);
        chk("stretch_err_cnt", 32'(err_cnt), 32'(STATS));
        fs0 = fs_n; err0 = err_n;
        send_frame(-1, -1);
        send_frame(-1, -1);
        send_frame(-1, -1);
        chk("relock_at_fs3", 32'(lock_rise_fs - fs0), 32'd3);
        chk("relocked", 32'(locked), 32'd1);
        chk("relock_no_err", 32'(err_n - err0), 32'd0);

        // Short hsync while in CHECK
        err0 = err_n;
        send_frame(5, -1);
        send_frame(-1, 3);
        chk("short_hs_err", 32'(err_n - err0), 32'd2);
        chk("short_hs_unlocked", 32'(locked), 32'd0);
        send_frame(-1, -1);
        chk("no_lock_after_short", 32'(locked), 32'd0);
        chk("err_cnt_3", 32'(err_cnt), 32'(3 * STATS));

        // Reset in the middle of an active line
        for (int ln = 0; ln < 7; ln++) send_line(ln, HE, HA, (ln < VA) ? 0 : HE + 2);
        send_line(7, 12, HA, HE + 2);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midline_reset");
        for (int i = 0; i < 3; i++) px(1'b1, 1'b1, 30'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) px(1'b1, 1'b1, 30'd0);
        fs0 = fs_n; err0 = err_n;
        send_frame(-1, -1);
        send_frame(-1, -1);
        chk("rst_unlocked_2", 32'(locked), 32'd0);
        send_frame(-1, -1);
        chk("rst_lock_at_fs3", 32'(lock_rise_fs - fs0), 32'd3);
        chk("rst_locked", 32'(locked), 32'd1);
        chk("rst_no_err", 32'(err_n - err0), 32'd0);

        // vsync falling mid-line defers the frame start to the next line start
        fs0 = fs_n; err0 = err_n;
        send_line(0, HE, HA, 10);
        px(1'b0, 1'b0, 30'd0);
        px(1'b0, 1'b0, 30'd0);
        @(negedge clk);
        chk("midline_no_fs_early", 32'(fs_n - fs0), 32'd0);
        px(1'b0, 1'b0, 30'd0);
        @(negedge clk);
        chk("midline_fs_pulse", 32'(frame_start), 32'd1);
        chk("midline_err", 32'(err), 32'd1);
        chk("midline_v_total", 32'(v_total), 32'd17);
        chk("midline_pix_y_wrap", 32'(pix_y), 32'h3FC);
        chk("midline_unlocked", 32'(locked), 32'd0);
        for (int hc = 3; hc < HE; hc++) px(hc >= HA, 1'b0, 30'd0);
        send_line(2, HE, HA, 0);
        send_line(3, HE, HA, HE + 2);
        send_line(4, HE, HA, HE + 2);
        px(1'b0, 1'b1, 30'd0);
        px(1'b0, 1'b1, 30'd0);
        px(1'b0, 1'b1, 30'd0);
        @(negedge clk);
        chk("new_frame_pix_y", 32'(pix_y), 32'd0);
        chk("new_frame_pix_x", 32'(pix_x), 32'h7F8);
        chk("midline_err_once", 32'(err_n - err0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
